csa_accumulator: RTL and testbench

CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

---
 rtl/csa_pkg.sv | 15 +
 rtl/csa_accumulator_full_adder.sv | 14 +
 rtl/csa_accumulator.sv | 133 +++++++++++++
 tb/tb_csa_accumulator.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save accumulator: FSM states, the resolve
// chunk width and the default operand/guard widths.
package csa_pkg;

   typedef enum logic [1:0] {
      ST_ACC     = 2'd0,
      ST_RESOLVE = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   localparam int CHUNK = 8;
   localparam int DEF_N = 32;
   localparam int DEF_G = 8;

endpackage

// File: rtl/csa_accumulator_full_adder.sv
// Single-bit full adder cell; the accumulator instantiates one per bit as a
// 3:2 compressor.
module csa_accumulator_full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/csa_accumulator.sv
// Carry-save group accumulator: operands are compressed into (S, C) at one per
// cycle, then the redundant pair is resolved 8 bits per cycle before output.
module csa_accumulator
   import csa_pkg::*;
#(
   parameter int N = DEF_N,
   parameter int G = DEF_G
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_sum,
   output logic         out_wrap,
   output logic [G-1:0] out_count
);

   localparam int W      = N + G;
   localparam int NCHUNK = W / CHUNK;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [G-1:0]  CNT_CLOSE = G'((1 << G) - 2);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NCHUNK - 1);

   state_t          state_reg, state_next;
   logic [W-1:0]    s_reg, c_reg, res_reg;
   logic [G-1:0]    cnt_reg;
   logic [IW-1:0]   idx_reg;
   logic            carry_reg;

   logic [W-1:0]    d_ext, fa_sum, fa_carry, c_next;
   logic [CHUNK:0]  chunk_full;
   logic            accept, close_group;
   logic            unused_top_carry;

   assign d_ext = {{G{1'b0}}, in_data};

   generate
      for (genvar gi = 0; gi < W; gi++) begin : g_csa
         csa_accumulator_full_adder u_fa (
            .a  (s_reg[gi]),
            .b  (c_reg[gi]),
            .ci (d_ext[gi]),
            .s  (fa_sum[gi]),
            .co (fa_carry[gi])
         );
      end
   endgenerate

   // The top carry is provably zero because the group sum always fits in W bits.
   assign c_next           = {fa_carry[W-2:0], 1'b0};
   assign unused_top_carry = fa_carry[W-1];

   assign accept      = (state_reg == ST_ACC) && in_valid;
   assign close_group = accept && (in_last || (cnt_reg == CNT_CLOSE));
   assign chunk_full  = {1'b0, s_reg[CHUNK-1:0]} + {1'b0, c_reg[CHUNK-1:0]}
                      + {{CHUNK{1'b0}}, carry_reg};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= ST_ACC;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state_reg)
         ST_ACC: begin
            in_ready = 1'b1;
            if (close_group) state_next = ST_RESOLVE;
         end
         ST_RESOLVE: begin
            if (idx_reg == IDX_LAST) state_next = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = ST_ACC;
         end
         default: state_next = ST_ACC;
      endcase
   end

   // Resolution shifts S and C down a chunk per cycle and fills R from the top.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_reg     <= '0;
         c_reg     <= '0;
         res_reg   <= '0;
         cnt_reg   <= '0;
         idx_reg   <= '0;
         carry_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_ACC: begin
               if (accept) begin
                  s_reg     <= fa_sum;
                  c_reg     <= c_next;
                  cnt_reg   <= cnt_reg + 1'b1;
                  idx_reg   <= '0;
                  carry_reg <= 1'b0;
               end
            end
            ST_RESOLVE: begin
               res_reg   <= {chunk_full[CHUNK-1:0], res_reg[W-1:CHUNK]};
               s_reg     <= s_reg >> CHUNK;
               c_reg     <= c_reg >> CHUNK;
               carry_reg <= chunk_full[CHUNK];
               idx_reg   <= idx_reg + 1'b1;
            end
            ST_DONE: begin
               if (out_ready) begin
                  s_reg     <= '0;
                  c_reg     <= '0;
                  res_reg   <= '0;
                  cnt_reg   <= '0;
                  idx_reg   <= '0;
                  carry_reg <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_sum   = out_valid ? res_reg[N-1:0] : '0;
   assign out_wrap  = out_valid ? |res_reg[W-1:N] : 1'b0;
   assign out_count = out_valid ? cnt_reg : '0;

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed bench for csa_accumulator: each task drives one scenario and
// checks outputs against hand-computed values.
module tb_csa_accumulator;

   localparam int N = 32;
   localparam int G = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [N-1:0] in_data = '0;
   logic         in_last = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [N-1:0] out_sum;
   logic         out_wrap;
   logic [G-1:0] out_count;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   csa_accumulator #(.N(N), .G(G)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_wrap  (out_wrap),
      .out_count (out_count)
   );

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [N-1:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      step(1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   // Waits out the resolve latency after a closing operand and checks the timing.
   task automatic wait_result(input string name);
      step(4);
      compared++;
      if (out_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL %s_early_valid: out_valid=%b required 0 at edge 4", name, out_valid);
      end
      step(1);
      compared++;
      if (out_valid !== 1'b1) begin
         mismatched++;
         $display("FAIL %s_valid: out_valid=%b required 1 at edge 5", name, out_valid);
      end
   endtask

   task automatic take_result();
      out_ready = 1'b1;
      step(1);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      step(2);
      rst = 1'b1;
      #2;
      compared++;
      if (out_valid !== 1'b0 || out_sum !== '0 || out_count !== '0) begin
         mismatched++;
         $display("FAIL reset_outputs: valid=%b sum=%h count=%0d required 0/0/0", out_valid, out_sum, out_count);
      end
      step(1);
      rst = 1'b0;
      step(1);
      compared++;
      if (in_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL reset_in_ready: in_ready=%b required 1", in_ready);
      end
      $display("reset: checked idle outputs and in_ready");
   endtask

   task automatic test_single();
      send(32'h0000_0005, 1'b1);
      compared++;
      if (in_ready !== 1'b0) begin
         mismatched++;
         $display("FAIL single_in_ready: in_ready=%b required 0 in resolve", in_ready);
      end
      wait_result("single");
      compared++;
      if (out_sum !== 32'h0000_0005 || out_wrap !== 1'b0 || out_count !== 8'd1) begin
         mismatched++;
         $display("FAIL single_result: sum=%h wrap=%b count=%0d required 00000005/0/1", out_sum, out_wrap, out_count);
      end
      take_result();
      compared++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL single_handshake: valid=%b in_ready=%b required 0/1", out_valid, in_ready);
      end
      $display("single: 0x5 -> sum=%h wrap=%b count=%0d", 32'h5, 1'b0, 1);
   endtask

   task automatic test_wrap();
      send(32'hFFFF_FFFF, 1'b0);
      send(32'hFFFF_FFFF, 1'b0);
      send(32'hFFFF_FFFF, 1'b1);
      wait_result("wrap");
      compared++;
      if (out_sum !== 32'hFFFF_FFFD || out_wrap !== 1'b1 || out_count !== 8'd3) begin
         mismatched++;
         $display("FAIL wrap_result: sum=%h wrap=%b count=%0d required FFFFFFFD/1/3", out_sum, out_wrap, out_count);
      end
      take_result();
      $display("wrap: 3 x FFFFFFFF checked");
   endtask

   task automatic test_backpressure();
      int bad;
      send(32'd7, 1'b0);
      send(32'd8, 1'b1);
      wait_result("bp");
      // Junk on the input side must be ignored while the result is pending.
      in_valid = 1'b1;
      in_data  = 32'h1234_5678;
      in_last  = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         compared++;
         if (out_valid !== 1'b1 || out_sum !== 32'd15 || out_count !== 8'd2 || in_ready !== 1'b0) begin
            mismatched++;
            bad++;
            $display("FAIL bp_hold_%0d: valid=%b sum=%0d count=%0d in_ready=%b required 1/15/2/0", i, out_valid, out_sum, out_count, in_ready);
         end
         step(1);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
      take_result();
      compared++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL bp_release: in_ready=%b valid=%b required 1/0", in_ready, out_valid);
      end
      $display("backpressure: 7+8 held 10 cycles, %0d bad cycles", bad);
   endtask

   task automatic test_forced_close();
      for (int i = 0; i < 254; i++) send(32'hFFFF_FFFF, 1'b0);
      compared++;
      if (in_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL forced_early_close: in_ready=%b required 1 after 254 operands", in_ready);
      end
      send(32'hFFFF_FFFF, 1'b0);
      compared++;
      if (in_ready !== 1'b0) begin
         mismatched++;
         $display("FAIL forced_close: in_ready=%b required 0 after 255 operands", in_ready);
      end
      wait_result("forced");
      compared++;
      if (out_sum !== 32'hFFFF_FF01 || out_wrap !== 1'b1 || out_count !== 8'd255) begin
         mismatched++;
         $display("FAIL forced_result: sum=%h wrap=%b count=%0d required FFFFFF01/1/255", out_sum, out_wrap, out_count);
      end
      take_result();
      $display("forced_close: 255 x FFFFFFFF checked");
   endtask

   task automatic test_reset_resolve();
      int seen;
      send(32'd9, 1'b1);
      step(2);
      rst = 1'b1;
      #2;
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         step(1);
         if (out_valid !== 1'b0) seen++;
      end
      compared++;
      if (seen != 0 || in_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL rst_resolve_discard: valid cycles=%0d in_ready=%b required 0/1", seen, in_ready);
      end
      send(32'd1, 1'b0);
      send(32'd2, 1'b1);
      wait_result("rst_next");
      compared++;
      if (out_sum !== 32'd3 || out_wrap !== 1'b0 || out_count !== 8'd2) begin
         mismatched++;
         $display("FAIL rst_next_result: sum=%0d wrap=%b count=%0d required 3/0/2", out_sum, out_wrap, out_count);
      end
      take_result();
      $display("reset_in_resolve: partial discarded, next group 1+2 checked");
   endtask

   task automatic test_back_to_back();
      send(32'd50, 1'b1);
      wait_result("b2b_first");
      // Operand held through the handshake edge must only be taken one edge later.
      in_valid  = 1'b1;
      in_data   = 32'd100;
      in_last   = 1'b1;
      out_ready = 1'b1;
      step(1);
      out_ready = 1'b0;
      compared++;
      if (in_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL b2b_no_same_edge: in_ready=%b required 1 after handshake", in_ready);
      end
      step(1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
      wait_result("b2b_second");
      compared++;
      if (out_sum !== 32'd100 || out_count !== 8'd1) begin
         mismatched++;
         $display("FAIL b2b_result: sum=%0d count=%0d required 100/1", out_sum, out_count);
      end
      take_result();
      $display("back_to_back: 50 then 100 checked");
   endtask

   initial begin
      test_reset();
      test_single();
      test_wrap();
      test_backpressure();
      test_forced_close();
      test_reset_resolve();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
